io_command_arbiter: RTL
=======================

IO_COMMAND_ARBITER -- requirements
Module: io_command_arbiter

Interface
REQ-001 Parameter DATABITWIDTH, 16, width of one command word.
REQ-002 Parameter PORTBYTEWIDTH, 8, port width in bytes, multiple of 2.
REQ-003 Parameter BUFFERCOUNT, ((PORTBYTEWIDTH*8)<=DATABITWIDTH) ? 1 : (PORTBYTEWIDTH*8)/DATABITWIDTH, beats per command.
REQ-004 Parameter REQCOUNT, 4, number of requesters, 2..16.
REQ-005 Parameter WATCHDOGCYCLES, 255, stall limit in clk_en cycles.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 sync_rst_n  in  1  reset, synchronous and active-low.
REQ-008 clk_en  in  1  global enable; no state change while low.
REQ-009 ReqACK  in  REQCOUNT  per-requester valid for the current word.
REQ-010 ReqREQ  out  REQCOUNT  per-requester word-accepted strobe.
REQ-011 ReqLoadEn, ReqStoreEn  in  REQCOUNT each  command type per requester.
REQ-012 ReqData  in  REQCOUNT*DATABITWIDTH  current word per requester, requester i at bits [i*DATABITWIDTH +: DATABITWIDTH].
REQ-013 CmdACK  out  1  downstream word valid.
REQ-014 CmdREQ  in  1  downstream ready.
REQ-015 CmdLoadEn, CmdStoreEn  out  1 each  latched command type.
REQ-016 CmdWordEn  out  BUFFERCOUNT  one-hot beat index.
REQ-017 CmdData  out  DATABITWIDTH  granted requester's word.
REQ-018 GrantId  out  $clog2(REQCOUNT)  current owner; Busy  out  1  high outside IDLE.

Function
REQ-019 States: IDLE and ISSUE only.
REQ-020 IDLE: if any ReqACK and clk_en, choose the first asserted requester at or after RRPointer (wrapping), register it as GrantId, latch its LoadEn/StoreEn, clear BeatCount, go to ISSUE.
REQ-021 IDLE outputs: CmdACK=0, ReqREQ=0, CmdWordEn=0.
REQ-022 ISSUE: CmdACK=ReqACK[GrantId]; CmdWordEn=one-hot(BeatCount); CmdData=ReqData[GrantId]; ReqREQ[GrantId]=CmdACK && CmdREQ; all other ReqREQ=0.
REQ-023 Beat accepted when CmdACK && CmdREQ && clk_en; BeatCount increments by 1.
REQ-024 Acceptance at BeatCount==BUFFERCOUNT-1 ends the command: RRPointer=GrantId+1 modulo REQCOUNT, go to IDLE.
REQ-025 BUFFERCOUNT==1: every command is one beat with CmdWordEn=1'b1.
REQ-026 Owner dropping ReqACK mid-command stalls in ISSUE and keeps ownership; no abort, no beat skipped.
REQ-027 Requests from non-owners are ignored until IDLE; minimum one IDLE cycle between commands.
REQ-028 Latency: first beat valid one cycle after the request is seen in IDLE.
REQ-029 Both ReqLoadEn and ReqStoreEn high: latch both unchanged; no check.

Reset
REQ-030 sync_rst_n low at an edge forces IDLE, GrantId=0, RRPointer=0, BeatCount=0, latched LoadEn/StoreEn=0, watchdog=0, regardless of clk_en.
REQ-031 Reset mid-command abandons the command; no ReqREQ and no CmdACK in the cycle after reset.

Configuration
REQ-032 Macro IO_COMMAND_ARBITER_WATCHDOG_EN defined: in ISSUE, counter increments per clk_en cycle without acceptance and clears on acceptance.
REQ-033 When the counter reaches WATCHDOGCYCLES, assert output WatchdogErr for one cycle, advance RRPointer past GrantId, go to IDLE.
REQ-034 Macro undefined: no counter, no WatchdogErr port, ISSUE waits indefinitely.

Structure
REQ-035 Shared package io_pkg holds the state enum (IDLE, ISSUE) and the BUFFERCOUNT derivation function.
REQ-036 One sub-module, io_rr_picker: combinational round-robin selector (request vector, pointer -> winner, found).

Verification
REQ-037 Reset, then req0 alone, BUFFERCOUNT=4, CmdREQ=1 -> CmdWordEn 0001,0010,0100,1000 on consecutive cycles, ReqREQ[0] four pulses, Busy falls after beat 4.
REQ-038 Req1 and req3 both held, RRPointer=2 -> req3 granted first, then req1, then req3; one IDLE cycle between commands.
REQ-039 CmdREQ low for 5 cycles at beat 2 -> CmdWordEn holds 0010 and CmdData is stable; no ReqREQ pulse until ready.
REQ-040 clk_en low for 3 cycles mid-command -> BeatCount, GrantId and RRPointer unchanged.
REQ-041 sync_rst_n low at beat 3 -> next cycle IDLE, CmdACK=0, GrantId=0.
REQ-042 With IO_COMMAND_ARBITER_WATCHDOG_EN, WATCHDOGCYCLES=8, CmdREQ=0 -> WatchdogErr pulses once after 8 cycles and the next requester is granted.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and helpers for the IO command arbiter: FSM state encoding and
// the beats-per-command derivation used as the BUFFERCOUNT default.
package io_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Beats needed to fill one port-width command with data-width words.
    function automatic int unsigned calc_buffer_count(input int unsigned port_bytes,
                                                      input int unsigned data_bits);
        return ((port_bytes * 8) <= data_bits) ? 1 : (port_bytes * 8) / data_bits;
    endfunction

endpackage

// File: rtl/io_rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo N.
module io_rr_picker #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = W'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/io_command_arbiter.sv
// Round-robin arbiter issuing multi-beat commands from REQCOUNT requesters to one
// downstream port. Optional stall watchdog enabled by IO_COMMAND_ARBITER_WATCHDOG_EN.
module io_command_arbiter
    import io_pkg::*;
#(
    parameter int unsigned DATABITWIDTH   = 16,
    parameter int unsigned PORTBYTEWIDTH  = 8,
    parameter int unsigned BUFFERCOUNT    = calc_buffer_count(PORTBYTEWIDTH, DATABITWIDTH),
    parameter int unsigned REQCOUNT       = 4,
    parameter int unsigned WATCHDOGCYCLES = 255
) (
    input  logic                             clk,
    input  logic                             sync_rst_n,
    input  logic                             clk_en,
    input  logic [REQCOUNT-1:0]              ReqACK,
    output logic [REQCOUNT-1:0]              ReqREQ,
    input  logic [REQCOUNT-1:0]              ReqLoadEn,
    input  logic [REQCOUNT-1:0]              ReqStoreEn,
    input  logic [REQCOUNT*DATABITWIDTH-1:0] ReqData,
    output logic                             CmdACK,
    input  logic                             CmdREQ,
    output logic                             CmdLoadEn,
    output logic                             CmdStoreEn,
    output logic [BUFFERCOUNT-1:0]           CmdWordEn,
    output logic [DATABITWIDTH-1:0]          CmdData,
    output logic [$clog2(REQCOUNT)-1:0]      GrantId,
    output logic                             Busy
`ifdef IO_COMMAND_ARBITER_WATCHDOG_EN
    ,
    output logic                             WatchdogErr
`endif
);

    localparam int unsigned GRANT_W = $clog2(REQCOUNT);
    localparam int unsigned BEAT_W  = (BUFFERCOUNT > 1) ? $clog2(BUFFERCOUNT) : 1;

    if (REQCOUNT < 2 || REQCOUNT > 16 || (PORTBYTEWIDTH % 2) != 0 || WATCHDOGCYCLES == 0)
    begin : g_bad_cfg
        $error("io_command_arbiter: unsupported parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_id_q, grant_id_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               load_en_q, load_en_d;
    logic               store_en_q, store_en_d;

    logic                    pick_found;
    logic [GRANT_W-1:0]      pick_id;
    logic                    sel_ack;
    logic [DATABITWIDTH-1:0] sel_data;
    logic                    accept;
    logic                    last_beat;
    logic [GRANT_W-1:0]      ptr_after_grant;
    logic                    wdog_trip;

`ifdef IO_COMMAND_ARBITER_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WATCHDOGCYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    io_rr_picker #(
        .N (REQCOUNT),
        .W (GRANT_W)
    ) u_picker (
        .req    (ReqACK),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    // Owner's valid and word, muxed by the registered grant.
    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < REQCOUNT; i++) begin
            if (GRANT_W'(i) == grant_id_q) begin
                sel_ack  = ReqACK[i];
                sel_data = ReqData[i*DATABITWIDTH +: DATABITWIDTH];
            end
        end
    end

    always_comb begin
        accept          = (state_q == ISSUE) && sel_ack && CmdREQ && clk_en;
        last_beat       = (beat_cnt_q == BEAT_W'(BUFFERCOUNT - 1));
        ptr_after_grant = (grant_id_q == GRANT_W'(REQCOUNT - 1)) ? '0 : grant_id_q + GRANT_W'(1);
`ifdef IO_COMMAND_ARBITER_WATCHDOG_EN
        wdog_trip = (state_q == ISSUE) && clk_en && !accept &&
                    ((wdog_q + WDOG_W'(1)) == WDOG_W'(WATCHDOGCYCLES));
`else
        wdog_trip = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // FSM next state; nothing moves while clk_en is low.
    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            case (state_q)
                IDLE:    if (pick_found) state_d = ISSUE;
                ISSUE:   if ((accept && last_beat) || wdog_trip) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: drive the downstream port only while a command is owned.
    always_comb begin
        CmdACK    = 1'b0;
        ReqREQ    = '0;
        CmdWordEn = '0;
        CmdData   = '0;
        if (state_q == ISSUE) begin
            CmdACK    = sel_ack;
            CmdWordEn = BUFFERCOUNT'(1) << beat_cnt_q;
            CmdData   = sel_data;
            if (sel_ack && CmdREQ) ReqREQ[grant_id_q] = 1'b1;
        end
    end

    // Grant, pointer, beat and command-type bookkeeping.
    always_comb begin
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        load_en_d  = load_en_q;
        store_en_d = store_en_q;
        if (clk_en) begin
            if (state_q == IDLE) begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    load_en_d  = ReqLoadEn[pick_id];
                    store_en_d = ReqStoreEn[pick_id];
                end
            end else begin
                if (accept) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                if ((accept && last_beat) || wdog_trip) rr_ptr_d = ptr_after_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            load_en_q  <= 1'b0;
            store_en_q <= 1'b0;
        end else begin
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            load_en_q  <= load_en_d;
            store_en_q <= store_en_d;
        end
    end

`ifdef IO_COMMAND_ARBITER_WATCHDOG_EN
    // Stall counter: counts enabled ISSUE cycles without an accepted beat.
    always_comb begin
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;
        if (clk_en) begin
            wdog_err_d = wdog_trip;
            if (state_q != ISSUE || accept || wdog_trip) wdog_d = '0;
            else                                         wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign WatchdogErr = wdog_err_q;
`endif

    assign CmdLoadEn  = load_en_q;
    assign CmdStoreEn = store_en_q;
    assign GrantId    = grant_id_q;
    assign Busy       = (state_q != IDLE);

endmodule
